cap_burstwr: RTL and testbench
==============================

CAP_BURSTWR -- requirements
Module: cap_burstwr

Interface
REQ-001 SHALL have parameter DATA_W, default 64: AXI write data width in bits, one of 32/64/128.
REQ-002 SHALL have parameter BURST_LEN, default 32: beats per burst, power of two, 2..256.
REQ-003 SHALL have parameter CNT_W, default 11: width of the FIFO level input.
REQ-004 SHALL have ports: ACLK in 1, the single clock; ARST in 1, reset, synchronous active-high.
REQ-005 SHALL have ports: FRAME_START in 1, pulse that starts a frame; CAP_ON in 1, capture enable.
REQ-006 SHALL have ports: BASE_ADDR0 in 29, frame buffer 0 byte address; BASE_ADDR1 in 29, frame buffer 1 byte address.
REQ-007 SHALL have port FRAME_BEATS in 20: beats per frame, a nonzero multiple of BURST_LEN.
REQ-008 SHALL have FIFO ports (first-word-fall-through): FIFO_CNT in CNT_W; FIFO_DOUT in DATA_W; FIFO_RD out 1.
REQ-009 SHALL have AXI AW ports: AWADDR out 29; AWLEN out 8; AWVALID out 1; AWREADY in 1.
REQ-010 SHALL have AXI W ports: WDATA out DATA_W; WVALID out 1; WLAST out 1; WREADY in 1.
REQ-011 SHALL have AXI B ports: BRESP in 2; BVALID in 1; BREADY out 1.
REQ-012 SHALL have status ports: FRAME_DONE out 1, pulse; BUSY out 1; BUF_SEL out 1, buffer being written; ERR out 1, sticky.

Function
REQ-013 SHALL implement states IDLE, WAIT, ADDR, DATA, RESP.
REQ-014 IDLE->WAIT SHALL occur on FRAME_START with CAP_ON=1; a FRAME_START with CAP_ON=0 SHALL be ignored.
REQ-015 On IDLE->WAIT, SHALL latch FRAME_BEATS, clear the beat counter, and load the address register from the base of BUF_SEL.
REQ-016 WAIT->ADDR SHALL occur when FIFO_CNT >= BURST_LEN, so W data never underflows within a burst.
REQ-017 In ADDR, AWVALID SHALL be 1 with AWADDR = address register and AWLEN = BURST_LEN-1; AWADDR and AWLEN SHALL hold stable until AWREADY; ADDR->DATA on AWVALID&AWREADY.
REQ-018 In DATA: WVALID=1; WDATA=FIFO_DOUT; FIFO_RD=WVALID&WREADY (combinational); WLAST=1 on beat BURST_LEN-1 only.
REQ-019 DATA->RESP SHALL occur on the WLAST handshake; in RESP, BREADY=1.
REQ-020 On BVALID in RESP, SHALL advance the address register by BURST_LEN*DATA_W/8 and the beat counter by BURST_LEN.
REQ-021 After that BVALID: if beat counter == latched FRAME_BEATS, SHALL go to IDLE and pulse FRAME_DONE for 1 cycle; otherwise SHALL go to WAIT.
REQ-022 BRESP != 0 on any BVALID SHALL set ERR; ERR SHALL clear only on ARST.
REQ-023 FRAME_START outside IDLE (frame overrun) SHALL be recorded in a 1-bit pending flag.
REQ-024 A pending flag SHALL abandon the frame at the next RESP->(WAIT|IDLE) decision: go to WAIT with a fresh frame (REQ-015 actions, buffer toggled per REQ-031); no FRAME_DONE; flag cleared.
REQ-025 An in-flight burst SHALL always complete: no AW/W transfer shall be aborted or truncated.
REQ-026 CAP_ON falling SHALL take effect only in IDLE or WAIT (-> IDLE, no FRAME_DONE); ADDR/DATA/RESP SHALL complete the burst first.
REQ-027 Address arithmetic SHALL be 29-bit modulo 2^29; wrap SHALL NOT be flagged.
REQ-028 BUSY SHALL be 1 in every state except IDLE.

Reset
REQ-029 On ARST at any cycle, including mid-burst, SHALL enter IDLE with AWVALID, WVALID, WLAST, BREADY, FIFO_RD, FRAME_DONE, BUSY, ERR, BUF_SEL and the pending flag at 0, and AWADDR at 0.
REQ-030 Mid-burst reset SHALL NOT wait for the AXI handshake; the system SHALL reset the interconnect on the same ARST.

Configuration
REQ-031 With CAP_DBLBUF_EN defined, BUF_SEL SHALL toggle at each frame start except the first after reset (first frame writes buffer 0), ping-ponging BASE_ADDR0/BASE_ADDR1.
REQ-032 With CAP_DBLBUF_EN undefined, BUF_SEL SHALL be constant 0, BASE_ADDR1 SHALL be unused, and every frame SHALL write BASE_ADDR0.

Verification
REQ-033 Verification: DATA_W=64, BURST_LEN=32, FRAME_BEATS=64, BASE_ADDR0=0x100000, FIFO prefilled 64, ready signals always 1 -> AWADDR 0x100000 then 0x100100; 2 WLAST; FRAME_DONE once.
REQ-034 Verification: FIFO_CNT held at 31 for 50 cycles, then 32 -> AWVALID stays 0 until the cycle after FIFO_CNT=32.
REQ-035 Verification: WREADY toggling randomly, AWREADY delayed 5 cycles -> AWADDR stable while waiting; exactly 32 FIFO_RD pulses per burst; WDATA order matches FIFO order.
REQ-036 Verification: BRESP=2'b10 on the 2nd burst -> ERR=1 and remains 1 through the next frame; cleared by ARST.
REQ-037 Verification: FRAME_START during burst 1 of a 4-burst frame -> burst 1 completes; no FRAME_DONE; next AWADDR = base.
REQ-038 Verification: CAP_DBLBUF_EN defined, 3 frames -> AWADDR starts at BASE_ADDR0, BASE_ADDR1, BASE_ADDR0; ARST asserted during DATA -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/cap_burstwr_if.sv
// FIFO read port and AXI write-channel bundle for the frame capture burst writer.
// master = burst writer side, slave = FIFO/interconnect side.
interface cap_burstwr_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 11
);
  logic [CNT_W-1:0]  FIFO_CNT;
  logic [DATA_W-1:0] FIFO_DOUT;
  logic              FIFO_RD;

  logic [28:0]       AWADDR;
  logic [7:0]        AWLEN;
  logic              AWVALID;
  logic              AWREADY;

  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WLAST;
  logic              WREADY;

  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    input  FIFO_CNT, FIFO_DOUT,
    output FIFO_RD,
    output AWADDR, AWLEN, AWVALID,
    input  AWREADY,
    output WDATA, WVALID, WLAST,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY
  );

  modport slave (
    output FIFO_CNT, FIFO_DOUT,
    input  FIFO_RD,
    input  AWADDR, AWLEN, AWVALID,
    output AWREADY,
    input  WDATA, WVALID, WLAST,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/cap_burstwr.sv
// Frame capture writer: drains a FWFT FIFO into fixed-length AXI write bursts; CAP_DBLBUF_EN enables ping-pong buffers.
// Latency: a burst is issued the cycle after FIFO_CNT >= BURST_LEN; W data streams combinationally from the FIFO head.
// Backpressure: AWREADY/WREADY/BVALID stall the FSM; bursts never start without a full burst of data buffered.
module cap_burstwr #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 32,
  parameter int CNT_W     = 11
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        FRAME_START,
  input  logic        CAP_ON,
  input  logic [28:0] BASE_ADDR0,
  input  logic [28:0] BASE_ADDR1,
  input  logic [19:0] FRAME_BEATS,
  cap_burstwr_if.master bus,
  output logic        FRAME_DONE,
  output logic        BUSY,
  output logic        BUF_SEL,
  output logic        ERR
);

  localparam int                BEAT_W    = $clog2(BURST_LEN);
  localparam logic [28:0]       ADDR_INC  = 29'(BURST_LEN * DATA_W / 8);
  localparam logic [19:0]       BEAT_INC  = 20'(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [28:0]       addr_q;
  logic [19:0]       beat_cnt_q;
  logic [19:0]       frame_beats_q;
  logic [BEAT_W-1:0] wbeat_q;
  logic              buf_sel_q;
  logic              pend_q;
  logic              err_q;
  logic              done_q;

  logic              start_frame;
  logic              burst_ok;
  logic              done_d;
  logic              w_hs;
  logic              fifo_ready;
  logic              sel_next;
  logic [28:0]       base_next;

`ifdef CAP_DBLBUF_EN
  // first_q keeps the first frame after reset on buffer 0
  logic first_q;

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      first_q <= 1'b1;
    end else if (start_frame) begin
      first_q <= 1'b0;
    end
  end

  assign sel_next  = first_q ? 1'b0 : ~buf_sel_q;
  assign base_next = sel_next ? BASE_ADDR1 : BASE_ADDR0;
`else
  logic unused_base1;

  assign unused_base1 = ^BASE_ADDR1;
  assign sel_next     = 1'b0;
  assign base_next    = BASE_ADDR0;
`endif

  assign fifo_ready = 32'(bus.FIFO_CNT) >= 32'(BURST_LEN);
  assign w_hs       = bus.WVALID && bus.WREADY;

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    burst_ok    = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (FRAME_START && CAP_ON) begin
          state_d     = S_WAIT;
          start_frame = 1'b1;
        end
      end
      S_WAIT: begin
        if (!CAP_ON) begin
          state_d = S_IDLE;
        end else if (fifo_ready) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.AWREADY) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs && bus.WLAST) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.BVALID) begin
          burst_ok = 1'b1;
          // an overrun abandons the current frame and restarts on a fresh buffer
          if (pend_q || FRAME_START) begin
            state_d     = S_WAIT;
            start_frame = 1'b1;
          end else if (beat_cnt_q + BEAT_INC == frame_beats_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      beat_cnt_q    <= '0;
      frame_beats_q <= '0;
      wbeat_q       <= '0;
      buf_sel_q     <= 1'b0;
      pend_q        <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;

      if (start_frame) begin
        frame_beats_q <= FRAME_BEATS;
        beat_cnt_q    <= '0;
        addr_q        <= base_next;
        buf_sel_q     <= sel_next;
      end else if (burst_ok) begin
        addr_q     <= addr_q + ADDR_INC;
        beat_cnt_q <= beat_cnt_q + BEAT_INC;
      end

      // BURST_LEN is a power of two, so the beat index wraps to 0 after WLAST
      if (w_hs) begin
        wbeat_q <= wbeat_q + BEAT_W'(1);
      end

      if (bus.BVALID && (bus.BRESP != 2'b00)) begin
        err_q <= 1'b1;
      end

      if (start_frame || (state_d == S_IDLE)) begin
        pend_q <= 1'b0;
      end else if (FRAME_START && (state_q != S_IDLE)) begin
        pend_q <= 1'b1;
      end
    end
  end

  assign bus.AWVALID = (state_q == S_ADDR);
  assign bus.AWADDR  = addr_q;
  assign bus.AWLEN   = bus.AWVALID ? 8'(BURST_LEN - 1) : 8'd0;
  assign bus.WVALID  = (state_q == S_DATA);
  assign bus.WDATA   = bus.WVALID ? bus.FIFO_DOUT : '0;
  assign bus.WLAST   = bus.WVALID && (wbeat_q == LAST_BEAT);
  assign bus.FIFO_RD = w_hs;
  assign bus.BREADY  = (state_q == S_RESP);

  assign FRAME_DONE = done_q;
  assign BUSY       = (state_q != S_IDLE);
  assign BUF_SEL    = buf_sel_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_cap_burstwr.sv
// Directed bench for cap_burstwr: FWFT FIFO model, AW/W/B responders and a bus monitor feed immediate assertions.
module tb_cap_burstwr;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic        FRAME_START;
  logic        CAP_ON;
  logic [28:0] BASE_ADDR0;
  logic [28:0] BASE_ADDR1;
  logic [19:0] FRAME_BEATS;
  logic        FRAME_DONE;
  logic        BUSY;
  logic        BUF_SEL;
  logic        ERR;

  cap_burstwr_if #(.DATA_W(64), .CNT_W(11)) bus ();

  cap_burstwr #(.DATA_W(64), .BURST_LEN(32), .CNT_W(11)) dut (
    .ACLK(ACLK), .ARST(ARST), .FRAME_START(FRAME_START), .CAP_ON(CAP_ON),
    .BASE_ADDR0(BASE_ADDR0), .BASE_ADDR1(BASE_ADDR1), .FRAME_BEATS(FRAME_BEATS),
    .bus(bus),
    .FRAME_DONE(FRAME_DONE), .BUSY(BUSY), .BUF_SEL(BUF_SEL), .ERR(ERR)
  );

  always #5 ACLK = ~ACLK;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [63:0] fdata(input int k);
    return {32'hC0DE0000 ^ 32'(k), 32'(k) * 32'h9E3779B1};
  endfunction

  // FWFT FIFO model: head advances on every FIFO_RD
  int fifo_head = 0;
  assign bus.FIFO_DOUT = fdata(fifo_head);
  always @(posedge ACLK) if (bus.FIFO_RD) fifo_head <= fifo_head + 1;

  int wr_rand  = 0;
  int aw_delay = 0;
  int aw_cnt   = 0;
  always @(negedge ACLK) bus.WREADY <= (wr_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;

  always @(posedge ACLK) begin
    if (ARST) begin
      bus.AWREADY <= 1'b0;
      aw_cnt      <= 0;
    end else if (!bus.AWVALID || bus.AWREADY) begin
      aw_cnt      <= 0;
      bus.AWREADY <= (aw_delay == 0);
    end else begin
      aw_cnt      <= aw_cnt + 1;
      bus.AWREADY <= (aw_cnt + 1 >= aw_delay);
    end
  end

  int b_n        = 0;
  int err_burst  = -1;
  always @(posedge ACLK) begin
    if (ARST) begin
      bus.BVALID <= 1'b0;
      bus.BRESP  <= 2'b00;
    end else if (bus.BVALID && bus.BREADY) begin
      bus.BVALID <= 1'b0;
      bus.BRESP  <= 2'b00;
      b_n        <= b_n + 1;
    end else if (bus.WVALID && bus.WREADY && bus.WLAST) begin
      bus.BVALID <= 1'b1;
      bus.BRESP  <= (b_n + 1 == err_burst) ? 2'b10 : 2'b00;
    end
  end

  logic [28:0] aw_log [0:255];
  logic [28:0] aw_prev = '0;
  int aw_n = 0, wlast_n = 0, done_n = 0, rd_n = 0, w_n = 0;
  int burst_rd = 0, burst_bad = 0, wdata_bad = 0, awlen_bad = 0, aw_unstable = 0;
  bit aw_hold = 0;

  always @(posedge ACLK) begin
    if (ARST) begin
      aw_hold  = 0;
      burst_rd = 0;
    end else begin
      if (aw_hold && (!bus.AWVALID || bus.AWADDR !== aw_prev)) aw_unstable++;
      aw_hold = bus.AWVALID && !bus.AWREADY;
      aw_prev = bus.AWADDR;
      if (bus.AWVALID && bus.AWREADY) begin
        aw_log[aw_n] = bus.AWADDR;
        if (bus.AWLEN !== 8'd31) awlen_bad++;
        aw_n++;
      end
      if (bus.FIFO_RD) begin
        rd_n++;
        burst_rd++;
      end
      if (bus.WVALID && bus.WREADY) begin
        if (bus.WDATA !== fdata(w_n)) wdata_bad++;
        w_n++;
        if (bus.WLAST) begin
          wlast_n++;
          if (burst_rd != 32) burst_bad++;
          burst_rd = 0;
        end
      end
      if (FRAME_DONE) done_n++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [19:0] beats);
    @(negedge ACLK);
    FRAME_BEATS = beats;
    FRAME_START = 1'b1;
    @(negedge ACLK);
    FRAME_START = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int c = 0;
    while (BUSY && c < max) begin
      @(negedge ACLK);
      c++;
    end
    chk(tag, 64'(BUSY), 64'd0);
    repeat (2) @(negedge ACLK);
  endtask

  task automatic wait_aw(input int n, input int max, input string tag);
    int c = 0;
    while (aw_n < n && c < max) begin
      @(negedge ACLK);
      c++;
    end
    chk(tag, 64'(aw_n >= n), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [28:0] B0 = 29'h100000;
  localparam logic [28:0] B1 = 29'h200000;
`ifdef CAP_DBLBUF_EN
  localparam logic [28:0] EXP_F2  = B1;
  localparam logic        EXP_SEL2 = 1'b1;
`else
  localparam logic [28:0] EXP_F2  = B0;
  localparam logic        EXP_SEL2 = 1'b0;
`endif

  initial begin
    int a0, r0, wl0, d0, c;
    bit early;
    ARST = 1'b1; FRAME_START = 1'b0; CAP_ON = 1'b1;
    BASE_ADDR0 = B0; BASE_ADDR1 = B0; FRAME_BEATS = 20'd64;
    bus.FIFO_CNT = 11'd64;
    repeat (3) @(negedge ACLK);

    chk("rst_awvalid", 64'(bus.AWVALID), 0);
    chk("rst_wvalid", 64'(bus.WVALID), 0);
    chk("rst_wlast", 64'(bus.WLAST), 0);
    chk("rst_bready", 64'(bus.BREADY), 0);
    chk("rst_fifo_rd", 64'(bus.FIFO_RD), 0);
    chk("rst_frame_done", 64'(FRAME_DONE), 0);
    chk("rst_busy", 64'(BUSY), 0);
    chk("rst_err", 64'(ERR), 0);
    chk("rst_buf_sel", 64'(BUF_SEL), 0);
    chk("rst_awaddr", 64'(bus.AWADDR), 0);
    ARST = 1'b0;
    @(negedge ACLK);

    // two back-to-back bursts with everything ready
    a0 = aw_n; r0 = rd_n; wl0 = wlast_n; d0 = done_n;
    start_frame(20'd64);
    chk("basic_busy", 64'(BUSY), 1);
    wait_idle(400, "basic_timeout");
    chk("basic_aw_count", 64'(aw_n - a0), 2);
    chk("basic_awaddr0", 64'(aw_log[a0]), 64'h100000);
    chk("basic_awaddr1", 64'(aw_log[a0 + 1]), 64'h100100);
    chk("basic_wlast", 64'(wlast_n - wl0), 2);
    chk("basic_done", 64'(done_n - d0), 1);
    chk("basic_rd", 64'(rd_n - r0), 64);
    chk("basic_wdata", 64'(wdata_bad), 0);
    chk("basic_awlen", 64'(awlen_bad), 0);

    // FIFO one beat short of a burst holds off AW
    d0 = done_n;
    bus.FIFO_CNT = 11'd31;
    start_frame(20'd32);
    early = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (bus.AWVALID) early = 1;
    end
    chk("short_no_aw", 64'(early), 0);
    bus.FIFO_CNT = 11'd32;
    chk("short_aw_same_cycle", 64'(bus.AWVALID), 0);
    @(negedge ACLK);
    chk("short_aw_next", 64'(bus.AWVALID), 1);
    wait_idle(200, "short_timeout");
    chk("short_done", 64'(done_n - d0), 1);
    bus.FIFO_CNT = 11'd64;

    // random WREADY, slow AWREADY
    a0 = aw_n; r0 = rd_n; wl0 = wlast_n;
    wr_rand = 1; aw_delay = 5;
    start_frame(20'd64);
    wait_idle(2000, "stall_timeout");
    wr_rand = 0; aw_delay = 0;
    chk("stall_aw_stable", 64'(aw_unstable), 0);
    chk("stall_rd_per_burst", 64'(burst_bad), 0);
    chk("stall_rd", 64'(rd_n - r0), 64);
    chk("stall_wlast", 64'(wlast_n - wl0), 2);
    chk("stall_wdata", 64'(wdata_bad), 0);
    chk("stall_aw_count", 64'(aw_n - a0), 2);

    // error response on the second burst is sticky until reset
    d0 = done_n;
    err_burst = b_n + 2;
    start_frame(20'd64);
    wait_idle(400, "err_timeout");
    chk("err_set", 64'(ERR), 1);
    chk("err_done", 64'(done_n - d0), 1);
    start_frame(20'd64);
    wait_idle(400, "err2_timeout");
    chk("err_sticky", 64'(ERR), 1);
    ARST = 1'b1;
    @(negedge ACLK);
    ARST = 1'b0;
    chk("err_cleared", 64'(ERR), 0);
    @(negedge ACLK);

    // start ignored while disabled; disable in WAIT returns to IDLE
    d0 = done_n;
    CAP_ON = 1'b0;
    start_frame(20'd32);
    chk("capoff_ignored", 64'(BUSY), 0);
    CAP_ON = 1'b1;
    bus.FIFO_CNT = 11'd0;
    start_frame(20'd32);
    chk("wait_busy", 64'(BUSY), 1);
    CAP_ON = 1'b0;
    @(negedge ACLK);
    chk("capoff_wait_idle", 64'(BUSY), 0);
    chk("capoff_no_done", 64'(done_n - d0), 0);
    CAP_ON = 1'b1;
    bus.FIFO_CNT = 11'd64;

    // overrun during burst 1 of a 4-burst frame
    a0 = aw_n; wl0 = wlast_n; d0 = done_n;
    start_frame(20'd128);
    wait_aw(a0 + 1, 100, "ovr_first_aw");
    FRAME_START = 1'b1;
    @(negedge ACLK);
    FRAME_START = 1'b0;
    wait_aw(a0 + 2, 200, "ovr_second_aw");
    chk("ovr_burst1_done", 64'(wlast_n - wl0), 1);
    chk("ovr_no_done", 64'(done_n - d0), 0);
    chk("ovr_restart_addr", 64'(aw_log[a0 + 1]), 64'(B0));
    wait_idle(800, "ovr_timeout");
    chk("ovr_aw_count", 64'(aw_n - a0), 5);
    chk("ovr_last_addr", 64'(aw_log[a0 + 4]), 64'(B0 + 29'h300));
    chk("ovr_done", 64'(done_n - d0), 1);

    // buffer selection over three frames, then reset mid-DATA
    ARST = 1'b1;
    @(negedge ACLK);
    ARST = 1'b0;
    BASE_ADDR1 = B1;
    a0 = aw_n;
    start_frame(20'd32);
    chk("f1_sel", 64'(BUF_SEL), 0);
    wait_idle(200, "f1_timeout");
    start_frame(20'd32);
    chk("f2_sel", 64'(BUF_SEL), 64'(EXP_SEL2));
    wait_idle(200, "f2_timeout");
    start_frame(20'd32);
    chk("f3_sel", 64'(BUF_SEL), 0);
    wait_idle(200, "f3_timeout");
    chk("f1_addr", 64'(aw_log[a0]), 64'(B0));
    chk("f2_addr", 64'(aw_log[a0 + 1]), 64'(EXP_F2));
    chk("f3_addr", 64'(aw_log[a0 + 2]), 64'(B0));

    start_frame(20'd64);
    c = 0;
    while (!bus.WVALID && c < 100) begin
      @(negedge ACLK);
      c++;
    end
    chk("mid_wvalid_seen", 64'(bus.WVALID), 1);
    ARST = 1'b1;
    @(negedge ACLK);
    chk("mid_rst_awvalid", 64'(bus.AWVALID), 0);
    chk("mid_rst_wvalid", 64'(bus.WVALID), 0);
    chk("mid_rst_wlast", 64'(bus.WLAST), 0);
    chk("mid_rst_wdata", bus.WDATA, 0);
    chk("mid_rst_bready", 64'(bus.BREADY), 0);
    chk("mid_rst_fifo_rd", 64'(bus.FIFO_RD), 0);
    chk("mid_rst_done", 64'(FRAME_DONE), 0);
    chk("mid_rst_busy", 64'(BUSY), 0);
    chk("mid_rst_buf_sel", 64'(BUF_SEL), 0);
    chk("mid_rst_awaddr", 64'(bus.AWADDR), 0);
    ARST = 1'b0;
    repeat (2) @(negedge ACLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
